// File: rtl/mem_berger_zero_scrubber.sv
// Read-side checker and background scrubber for a 16x12 Berger-zero-coded
// memory. Serves single-cycle host reads with a code check and, on request,
// walks every location and logs the words whose check field is wrong.
// Word layout: data = word[11:4], check = word[3:0] = number of zero data bits.
module mem_berger_zero_scrubber #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [AW-1:0]    mem_addr,
    input  logic [11:0]      mem_rdata,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_err,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [4:0]       err_count,
    output logic [DEPTH-1:0] err_map,
    output logic [AW-1:0]    first_err_addr,
    output logic             err_any
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    scan_ptr_q, scan_ptr_d;
    logic [4:0]       err_count_q, err_count_d;
    logic [DEPTH-1:0] err_map_q, err_map_d;
    logic [AW-1:0]    first_err_q, first_err_d;

    logic             rd_valid_q;
    logic [7:0]       rd_data_q;
    logic             rd_err_q;

    logic [3:0]       zero_cnt;
    logic             ok;

    // Host reads own the address port whenever they are requested.
    assign mem_addr = rd_req ? rd_addr : scan_ptr_q;

    // Count zero bits in the data field of the word currently on the bus.
    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first,
        // so no path can leave it holding its old value (which infers a latch).
        zero_cnt = 4'd0;
        for (int i = 4; i < 12; i++) begin
            zero_cnt = zero_cnt + {3'd0, ~mem_rdata[i]};
        end
    end

    // Check values 9..15 can never equal a zero count of 0..8, so they fail here.
    assign ok = (mem_rdata[3:0] == zero_cnt);

    // Scan controller: next state and error log updates.
    always_comb begin
        state_d     = state_q;
        scan_ptr_d  = scan_ptr_q;
        err_count_d = err_count_q;
        err_map_d   = err_map_q;
        first_err_d = first_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SCAN;
                    scan_ptr_d  = '0;
                    err_count_d = '0;
                    err_map_d   = '0;
                    first_err_d = '0;
                end
            end
            S_SCAN: begin
                // A host read steals the port; the scan simply stalls a cycle.
                if (!rd_req) begin
                    if (!ok) begin
                        err_map_d[scan_ptr_q] = 1'b1;
                        err_count_d           = err_count_q + 5'd1;
                        if (err_count_q == 5'd0) begin
                            first_err_d = scan_ptr_q;
                        end
                    end
                    if (scan_ptr_q == LAST_ADDR) begin
                        state_d = S_FIN;
                    end else begin
                        scan_ptr_d = scan_ptr_q + 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scan controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            scan_ptr_q  <= '0;
            err_count_q <= '0;
            err_map_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            scan_ptr_q  <= scan_ptr_d;
            err_count_q <= err_count_d;
            err_map_q   <= err_map_d;
            first_err_q <= first_err_d;
        end
    end

    // Host read result: registered one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= mem_rdata[11:4];
                rd_err_q  <= ~ok;
            end
        end
    end

    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign rd_err         = rd_err_q;
    assign busy           = (state_q == S_SCAN);
    assign done           = (state_q == S_FIN);
    assign err_count      = err_count_q;
    assign err_map        = err_map_q;
    assign first_err_addr = first_err_q;
    assign err_any        = (err_count_q != 5'd0);

endmodule

// File: tb/tb_mem_berger_zero_scrubber.sv
// Self-checking bench for mem_berger_zero_scrubber. A behavioural memory
// drives mem_rdata; expected results come from counting zero bits directly.
module tb_mem_berger_zero_scrubber;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_addr;
    logic [11:0] mem_rdata;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  err_count;
    logic [15:0] err_map;
    logic [3:0]  first_err_addr;
    logic        err_any;

    logic [11:0] mem [16];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    mem_berger_zero_scrubber #(.DEPTH(16), .AW(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .err_map        (err_map),
        .first_err_addr (first_err_addr),
        .err_any        (err_any)
    );

    // Reference rule: a word is valid iff its check field equals the number
    // of zero bits in its data byte.
    function automatic bit word_ok(input logic [11:0] w);
        logic [7:0] d;
        d = w[11:4];
        return int'(w[3:0]) == (8 - $countones(d));
    endfunction

    function automatic logic [11:0] make_valid(input logic [7:0] d);
        return {d, 4'(8 - $countones(d))};
    endfunction

    function automatic logic [11:0] make_bad(input logic [7:0] d);
        logic [3:0] c;
        c = 4'(8 - $countones(d)) + 4'(1 + $urandom_range(0, 14));
        return {d, c};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rd_req = 1'b0; rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rd_valid, rd_data, rd_err, busy, done, err_count, err_map, first_err_addr, err_any, mem_addr}
            !== '0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%h err=%b busy=%b done=%b cnt=%0d map=%h first=%0d any=%b addr=%0d, all required 0",
                     rd_valid, rd_data, rd_err, busy, done, err_count, err_map, first_err_addr, err_any, mem_addr);
        end
    endtask

    // One isolated host read of word w placed at address a.
    task automatic host_read(input logic [3:0] a, input logic [11:0] w);
        mem[a]  = w;
        rd_req  = 1'b1;
        rd_addr = a;
        #1;
        vectors++;
        if (mem_addr !== a) begin
            miscompares++;
            $display("FAIL host_addr: mem_addr=%0d required %0d", mem_addr, a);
        end
        @(negedge clk);
        rd_req = 1'b0;
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== w[11:4] || rd_err !== !word_ok(w)) begin
            miscompares++;
            $display("FAIL host_read word=%h: valid=%b data=%h err=%b required 1 %h %b",
                     w, rd_valid, rd_data, rd_err, w[11:4], !word_ok(w));
        end
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL host_pulse: rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_host_reads();
        logic [11:0] dir [6];
        dir = '{12'hF04, 12'hFF0, 12'h008, 12'hF05, 12'h000, 12'h00F};
        for (int i = 0; i < 6; i++) host_read(4'(i + 2), dir[i]);
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 1) == 1) host_read(4'($urandom), make_valid(8'($urandom)));
            else host_read(4'($urandom), make_bad(8'($urandom)));
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  a_prev;
        logic [11:0] w_prev;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) mem[i] = make_valid(8'($urandom));
            else mem[i] = make_bad(8'($urandom));
        end
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== w_prev[11:4] || rd_err !== !word_ok(w_prev)) begin
                    miscompares++;
                    $display("FAIL back_to_back #%0d: valid=%b data=%h err=%b required 1 %h %b",
                             i, rd_valid, rd_data, rd_err, w_prev[11:4], !word_ok(w_prev));
                end
            end
            if (i < 6) begin
                a_prev  = 4'($urandom);
                w_prev  = mem[a_prev];
                rd_req  = 1'b1;
                rd_addr = a_prev;
            end else begin
                rd_req = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    // Full scan from IDLE. Optional host-read stall window, and optional
    // stray start pulses while busy and during the done cycle.
    task automatic do_scan(input string name, input int stall_at, input int stall_len,
                           input bit poke_start);
        logic [15:0] exp_map;
        int          exp_cnt;
        logic [3:0]  exp_first;
        bit          found;
        int          cyc, done_cyc, busy_cyc;
        bit          prev_req;
        logic [3:0]  prev_addr;

        exp_map = '0; exp_cnt = 0; exp_first = '0; found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!word_ok(mem[i])) begin
                exp_map[i] = 1'b1;
                exp_cnt++;
                if (!found) begin
                    exp_first = 4'(i);
                    found = 1'b1;
                end
            end
        end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; done_cyc = 0; busy_cyc = 0; prev_req = 1'b0; prev_addr = '0;
        while (cyc < 60 && done_cyc == 0) begin
            if (prev_req) begin
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== mem[prev_addr][11:4]
                    || rd_err !== !word_ok(mem[prev_addr])) begin
                    miscompares++;
                    $display("FAIL %s stall_read: valid=%b data=%h err=%b required 1 %h %b", name,
                             rd_valid, rd_data, rd_err, mem[prev_addr][11:4], !word_ok(mem[prev_addr]));
                end
            end
            if (done === 1'b1) done_cyc = cyc;
            else if (busy === 1'b1) busy_cyc++;
            prev_req = 1'b0;
            if (stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len) begin
                rd_req    = 1'b1;
                rd_addr   = 4'($urandom);
                prev_req  = 1'b1;
                prev_addr = rd_addr;
            end else begin
                rd_req = 1'b0;
            end
            start = poke_start && (cyc == 4 || done_cyc != 0);
            @(negedge clk);
            cyc++;
        end
        start  = 1'b0;
        rd_req = 1'b0;

        vectors++;
        if (done_cyc != 17 + stall_len || busy_cyc != 16 + stall_len) begin
            miscompares++;
            $display("FAIL %s timing: done at T+%0d busy %0d cycles, required T+%0d and %0d", name,
                     done_cyc, busy_cyc, 17 + stall_len, 16 + stall_len);
        end
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_done: busy=%b done=%b required 0 0", name, busy, done);
        end
        vectors++;
        if (err_count !== 5'(exp_cnt) || err_map !== exp_map || first_err_addr !== exp_first
            || err_any !== (exp_cnt != 0)) begin
            miscompares++;
            $display("FAIL %s results: cnt=%0d map=%h first=%0d any=%b required %0d %h %0d %b", name,
                     err_count, err_map, first_err_addr, err_any, exp_cnt, exp_map, exp_first, exp_cnt != 0);
        end
        @(negedge clk);
        vectors++;
        if (err_count !== 5'(exp_cnt) || err_map !== exp_map || first_err_addr !== exp_first) begin
            miscompares++;
            $display("FAIL %s hold: cnt=%0d map=%h first=%0d required %0d %h %0d", name,
                     err_count, err_map, first_err_addr, exp_cnt, exp_map, exp_first);
        end
    endtask

    task automatic test_scans();
        for (int i = 0; i < 16; i++) mem[i] = 12'hF04;
        do_scan("scan_all_valid", 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;
        do_scan("scan_all_zero", 0, 0, 1'b0);
        for (int i = 0; i < 16; i++) mem[i] = make_valid(8'($urandom));
        mem[3]  = make_bad(8'($urandom));
        mem[12] = make_bad(8'($urandom));
        do_scan("scan_3_12", 0, 0, 1'b0);
        do_scan("scan_stalled", 6, 3, 1'b0);
        do_scan("scan_start_ignored", 0, 0, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) mem[i] = make_bad(8'($urandom));
                else mem[i] = make_valid(8'($urandom));
            end
            do_scan("scan_random", $urandom_range(2, 14), $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_scan_reset();
        bit seen_done;
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 8; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== 5'd0 || err_map !== 16'h0
            || first_err_addr !== 4'd0 || err_any !== 1'b0 || mem_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL scan_reset: busy=%b done=%b cnt=%0d map=%h first=%0d any=%b addr=%0d required all 0",
                     busy, done, err_count, err_map, first_err_addr, err_any, mem_addr);
        end
        seen_done = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (seen_done) begin
            miscompares++;
            $display("FAIL scan_reset_quiet: busy/done activity seen after abort, required none");
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 12'h000;
        test_reset();
        test_host_reads();
        test_back_to_back();
        test_scans();
        test_scan_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_berger_zero_scrubber.md
# mem_berger_zero_scrubber

Read-side checker and background scrubber for the 16×12 Berger-zero-coded memory. It drives the memory's address port and consumes its combinational read data. It serves single-word host reads with an immediate code check, and on request it walks all 16 locations, logging which words violate the code. It sits between the memory and the host/fault-reporting logic. It never writes the memory.

## Interface
Parameters:
- DEPTH, 16, number of words scanned (fixed to the memory depth)
- AW, 4, address width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- mem_addr  out  AW  address to memory; combinational: rd_req ? rd_addr : scan_ptr
- mem_rdata  in  12  combinational read data from the memory at mem_addr
- rd_req  in  1  host read request, one cycle per request
- rd_addr  in  AW  host read address, valid with rd_req
- rd_valid  out  1  one-cycle pulse; registered result of a host read
- rd_data  out  8  data field of the word read (word[11:4])
- rd_err  out  1  Berger check failed for the word read
- start  in  1  begin a full scan; ignored while busy
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion
- err_count  out  5  number of failing words in the last or current scan (0..16)
- err_map  out  DEPTH  bit i set if address i failed in the last or current scan
- first_err_addr  out  AW  lowest-index failing address of the scan; 0 if none
- err_any  out  1  err_count != 0

## Operation
- Word format: data = word[11:4], check = word[3:0]. The word is valid iff check == number of 0 bits in data (0..8).
- Check values 9..15 always fail. The all-zero word fails (8 zeros ≠ 0), so the memory's post-reset contents are flagged.
- The zero count is purely combinational on mem_rdata. The compare result is `ok`.
- Host read: in a cycle with rd_req=1, mem_addr=rd_addr. The next cycle has rd_valid=1, rd_data=mem_rdata[11:4], rd_err=!ok. Back-to-back requests give back-to-back results.
- FSM has three states: IDLE, SCAN, FIN.
  - IDLE: start=1 → SCAN. In the same edge, scan_ptr←0, err_count←0, err_map←0, first_err_addr←0.
  - SCAN, rd_req=0: the word at scan_ptr is checked. On failure, err_map[scan_ptr]←1 and err_count←err_count+1. On the first failure of the scan, first_err_addr←scan_ptr.
    - If scan_ptr==DEPTH-1 → FIN; otherwise scan_ptr←scan_ptr+1.
  - SCAN, rd_req=1: the host read has priority. No scan check happens, scan_ptr holds, and the scan stalls one cycle.
  - FIN: done=1 for one cycle → IDLE.
- busy=1 in SCAN only. start in SCAN or FIN is ignored. start in IDLE with rd_req=1 still starts the scan, and the first SCAN cycle follows normally.
- Error results hold after done until the next start or reset.
- scan_ptr never wraps past DEPTH-1 within a scan.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_err=0, busy=0, done=0, err_count=0, err_map=0, first_err_addr=0, err_any=0, FSM=IDLE, scan_ptr=0.
- rst asserted mid-scan aborts it: all state returns to reset values on that edge, and no done pulse is produced.
- Host read latency is 1 cycle (request at edge N, rd_valid high after edge N+1).
- Scan with start sampled at edge T and no host reads:
  - busy high for cycles T+1..T+16; address k is checked in cycle T+1+k.
  - done high in cycle T+17.
- Each host-read cycle during SCAN delays done by one cycle.
- Error outputs update on the edge ending the checking cycle, so they are visible the cycle after.
- err_any is combinational from err_count.

## Test plan
- Host reads with no scan: 12'hF04, 12'hFF0, 12'h008 → rd_err=0, rd_data=F0/FF/00. Then 12'hF05, 12'h000, 12'h00F → rd_err=1. Each result arrives one cycle after rd_req.
- Scan of a memory all valid (every word 12'hF04) → busy for 16 cycles, done at T+17, err_count=0, err_map=0, err_any=0.
- Scan of a memory just out of reset (all 12'h000) → err_count=16, err_map=16'hFFFF, first_err_addr=0.
- Scan with bad words only at addresses 3 and 12 → err_count=2, err_map=16'h1008, first_err_addr=3.
- Scan with rd_req asserted for 3 cycles mid-scan → three rd_valid results returned, done delayed to T+20, scan results identical to the unstalled run.
- rst asserted at cycle T+8 of a scan → busy=0, err_count=0, err_map=0, and no done pulse. A start issued while busy has no effect (results still from the original scan).
